player_move_ctrl: RTL and testbench

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

---
 rtl/player_move_ctrl_pkg.sv | 33 +++
 rtl/player_move_ctrl_aabb_overlap.sv | 23 ++
 rtl/player_move_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_player_move_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_move_ctrl_pkg.sv
// Shared types for the player movement controller: direction codes, FSM
// states and the packed {h, v} position layout.
package player_move_ctrl_pkg;

    localparam int COORD_W = 10;
    localparam int POS_W   = 2 * COORD_W;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    // move_req is {up, down, left, right}; only meaningful when one-hot.
    function automatic dir_t req_to_dir(input logic [3:0] req);
        dir_t d;
        case (req)
            4'b1000: d = DIR_UP;
            4'b0100: d = DIR_DOWN;
            4'b0010: d = DIR_LEFT;
            default: d = DIR_RIGHT;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/player_move_ctrl_aabb_overlap.sv
// Square-sprite overlap test between the movement candidate and one enemy:
// both axis distances must be strictly less than one tile edge.
module aabb_overlap
    import player_move_ctrl_pkg::*;
#(
    parameter int TILE_LOG2 = 5
) (
    input  logic [POS_W-1:0] cand,
    input  logic [POS_W-1:0] enemy,
    output logic             overlap
);

    localparam logic signed [COORD_W:0] EDGE = (COORD_W + 1)'(2 ** TILE_LOG2);

    logic signed [COORD_W:0] dh;
    logic signed [COORD_W:0] dv;

    assign dh = $signed({1'b0, cand[POS_W-1:COORD_W]}) - $signed({1'b0, enemy[POS_W-1:COORD_W]});
    assign dv = $signed({1'b0, cand[COORD_W-1:0]}) - $signed({1'b0, enemy[COORD_W-1:0]});

    assign overlap = (dh < EDGE) && (dh > -EDGE) && (dv < EDGE) && (dv > -EDGE);

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: samples a one-hot move request on each move
// tick, checks the candidate against the wall map and enemies, then commits.
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int N_ENEMY      = 5,
    parameter int STEP         = 2,
    parameter int MOVE_DIV     = 1,
    parameter int MAP_W        = 20,
    parameter int MAP_H        = 15,
    parameter int TILE_LOG2    = 5,
    parameter int H_ORIGIN     = 144,
    parameter int V_ORIGIN     = 31,
    parameter int START_H      = 180,
    parameter int START_V      = 32,
    parameter int HIT_COOLDOWN = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               move_req,
    input  logic [N_ENEMY*POS_W-1:0] enemy_pos,
    input  logic [MAP_W*MAP_H-1:0]   wall_map,
    output logic [POS_W-1:0]         position,
    output logic                     enemy_hit,
    output logic                     invuln,
    output logic [1:0]               facing,
    output logic                     busy
);

    localparam int DIV_MAX = (MOVE_DIV > 1) ? MOVE_DIV - 1 : 0;
    localparam int CNT_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int COOL_W  = (HIT_COOLDOWN > 0) ? $clog2(HIT_COOLDOWN + 1) : 1;
    localparam logic [COORD_W:0] STEP_X = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0] SPAN   = (COORD_W + 1)'(2 ** TILE_LOG2 - 1);

    state_t               state_reg;
    logic [CNT_W-1:0]     tick_cnt_reg;
    logic [COOL_W-1:0]    cool_reg;
    logic [COORD_W-1:0]   pos_h_reg;
    logic [COORD_W-1:0]   pos_v_reg;
    logic [COORD_W-1:0]   cand_h_reg;
    logic [COORD_W-1:0]   cand_v_reg;
    dir_t                 cand_dir_reg;
    logic                 cand_oob_reg;
    logic                 cand_valid_reg;
    logic [1:0]           facing_reg;
    logic                 enemy_hit_reg;
    logic                 invuln_reg;

    logic                 tick;
    logic                 expire;
    logic                 req_valid;
    dir_t                 req_dir;
    logic [COORD_W:0]     new_h;
    logic [COORD_W:0]     new_v;
    logic                 new_oob;
    logic                 wall_block;
    logic                 enemy_block;
    logic                 move_ok;
    logic [N_ENEMY-1:0]   overlap_vec;

    assign tick   = (tick_cnt_reg == CNT_W'(DIV_MAX));
    assign expire = (cool_reg <= COOL_W'(1));

    // Candidate is computed one bit wider so a step past 0 or 1023 shows up
    // as a carry/borrow and is treated as leaving the map.
    always_comb begin
        req_valid = $onehot(move_req);
        req_dir   = req_to_dir(move_req);
        new_h     = {1'b0, pos_h_reg};
        new_v     = {1'b0, pos_v_reg};
        case (req_dir)
            DIR_UP:    new_v = {1'b0, pos_v_reg} - STEP_X;
            DIR_DOWN:  new_v = {1'b0, pos_v_reg} + STEP_X;
            DIR_LEFT:  new_h = {1'b0, pos_h_reg} - STEP_X;
            default:   new_h = {1'b0, pos_h_reg} + STEP_X;
        endcase
        new_oob = new_h[COORD_W] | new_v[COORD_W];
    end

    // Pixels left of / above the origin, or past the map edge, read as wall.
    function automatic logic wall_at(input logic [COORD_W:0] ph,
                                     input logic [COORD_W:0] pv,
                                     input logic [MAP_W*MAP_H-1:0] map);
        int  col;
        int  row;
        logic w;
        col = 0;
        row = 0;
        if (int'(ph) < H_ORIGIN || int'(pv) < V_ORIGIN) begin
            w = 1'b1;
        end else begin
            col = (int'(ph) - H_ORIGIN) >> TILE_LOG2;
            row = (int'(pv) - V_ORIGIN) >> TILE_LOG2;
            if (col >= MAP_W || row >= MAP_H) begin
                w = 1'b1;
            end else begin
                w = map[row * MAP_W + col];
            end
        end
        return w;
    endfunction

    logic [COORD_W:0] h_lo, h_hi, v_lo, v_hi;
    logic [COORD_W:0] p0_h, p0_v, p1_h, p1_v;

    always_comb begin
        h_lo = {1'b0, cand_h_reg};
        v_lo = {1'b0, cand_v_reg};
        h_hi = h_lo + SPAN;
        v_hi = v_lo + SPAN;
        p0_h = h_lo;
        p0_v = v_lo;
        p1_h = h_hi;
        p1_v = v_lo;
        case (cand_dir_reg)
            DIR_UP: begin
                p0_h = h_lo; p0_v = v_lo; p1_h = h_hi; p1_v = v_lo;
            end
            DIR_DOWN: begin
                p0_h = h_lo; p0_v = v_hi; p1_h = h_hi; p1_v = v_hi;
            end
            DIR_LEFT: begin
                p0_h = h_lo; p0_v = v_lo; p1_h = h_lo; p1_v = v_hi;
            end
            default: begin
                p0_h = h_hi; p0_v = v_lo; p1_h = h_hi; p1_v = v_hi;
            end
        endcase
        wall_block = cand_oob_reg | wall_at(p0_h, p0_v, wall_map) | wall_at(p1_h, p1_v, wall_map);
    end

    for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
        aabb_overlap #(
            .TILE_LOG2 (TILE_LOG2)
        ) u_overlap (
            .cand    ({cand_h_reg, cand_v_reg}),
            .enemy   (enemy_pos[gi*POS_W +: POS_W]),
            .overlap (overlap_vec[gi])
        );
    end

    assign enemy_block = |overlap_vec;
    assign move_ok     = !wall_block && !enemy_block;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tick_cnt_reg   <= '0;
            cool_reg       <= '0;
            pos_h_reg      <= COORD_W'(START_H);
            pos_v_reg      <= COORD_W'(START_V);
            cand_h_reg     <= '0;
            cand_v_reg     <= '0;
            cand_dir_reg   <= DIR_DOWN;
            cand_oob_reg   <= 1'b0;
            cand_valid_reg <= 1'b0;
            facing_reg     <= DIR_DOWN;
            enemy_hit_reg  <= 1'b0;
            invuln_reg     <= 1'b0;
        end else begin
            enemy_hit_reg <= 1'b0;
            tick_cnt_reg  <= tick ? '0 : tick_cnt_reg + CNT_W'(1);
            case (state_reg)
                ST_IDLE: begin
                    if (tick && req_valid) begin
                        cand_h_reg     <= new_h[COORD_W-1:0];
                        cand_v_reg     <= new_v[COORD_W-1:0];
                        cand_dir_reg   <= req_dir;
                        cand_oob_reg   <= new_oob;
                        cand_valid_reg <= 1'b1;
                        state_reg      <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    cand_valid_reg <= 1'b0;
                    facing_reg     <= cand_dir_reg;
                    if (move_ok) begin
                        pos_h_reg <= cand_h_reg;
                        pos_v_reg <= cand_v_reg;
                    end
                    // Enemy contact wins over a simultaneous wall block.
                    if (enemy_block) begin
                        enemy_hit_reg <= 1'b1;
                        invuln_reg    <= 1'b1;
                        cool_reg      <= COOL_W'(HIT_COOLDOWN);
                        state_reg     <= ST_HIT;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_HIT: begin
                    if (tick) begin
                        if (expire) begin
                            cool_reg   <= '0;
                            invuln_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end else begin
                            cool_reg <= cool_reg - COOL_W'(1);
                        end
                    end
                    // Moves keep working while invulnerable, without new hits.
                    if (cand_valid_reg) begin
                        cand_valid_reg <= 1'b0;
                        facing_reg     <= cand_dir_reg;
                        if (move_ok) begin
                            pos_h_reg <= cand_h_reg;
                            pos_v_reg <= cand_v_reg;
                        end
                    end else if (tick && req_valid && !expire) begin
                        cand_h_reg     <= new_h[COORD_W-1:0];
                        cand_v_reg     <= new_v[COORD_W-1:0];
                        cand_dir_reg   <= req_dir;
                        cand_oob_reg   <= new_oob;
                        cand_valid_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign position  = {pos_h_reg, pos_v_reg};
    assign enemy_hit = enemy_hit_reg;
    assign invuln    = invuln_reg;
    assign facing    = facing_reg;
    assign busy      = cand_valid_reg;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed scenarios plus random play, all
// compared each clock against a pixel-level behavioural model.
module tb_player_move_ctrl;

    localparam int N_ENEMY      = 5;
    localparam int STEP         = 2;
    localparam int MOVE_DIV     = 1;
    localparam int MAP_W        = 20;
    localparam int MAP_H        = 15;
    localparam int TILE_LOG2    = 5;
    localparam int H_ORIGIN     = 144;
    localparam int V_ORIGIN     = 31;
    localparam int START_H      = 180;
    localparam int START_V      = 32;
    localparam int HIT_COOLDOWN = 60;
    localparam int TS           = 1 << TILE_LOG2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [3:0]               move_req;
    logic [N_ENEMY*20-1:0]    enemy_pos;
    logic [MAP_W*MAP_H-1:0]   wall_map;
    logic [19:0]              position;
    logic                     enemy_hit;
    logic                     invuln;
    logic [1:0]               facing;
    logic                     busy;

    always #5 clk = ~clk;

    player_move_ctrl #(
        .N_ENEMY(N_ENEMY), .STEP(STEP), .MOVE_DIV(MOVE_DIV), .MAP_W(MAP_W), .MAP_H(MAP_H),
        .TILE_LOG2(TILE_LOG2), .H_ORIGIN(H_ORIGIN), .V_ORIGIN(V_ORIGIN),
        .START_H(START_H), .START_V(START_V), .HIT_COOLDOWN(HIT_COOLDOWN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .move_req  (move_req),
        .enemy_pos (enemy_pos),
        .wall_map  (wall_map),
        .position  (position),
        .enemy_hit (enemy_hit),
        .invuln    (invuln),
        .facing    (facing),
        .busy      (busy)
    );

    int tests  = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int en_h [N_ENEMY];
    int en_v [N_ENEMY];

    int m_h, m_v, m_face, m_hit, m_cool, m_cnt;
    int m_pend, m_ch, m_cv, m_cdir, m_coob;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int wall_pt(input int px, input int py);
        int col, row;
        if (px < H_ORIGIN || py < V_ORIGIN) return 1;
        col = (px - H_ORIGIN) / TS;
        row = (py - V_ORIGIN) / TS;
        if (col >= MAP_W || row >= MAP_H) return 1;
        return int'(wall_map[row * MAP_W + col]);
    endfunction

    // The two corners on the side of the sprite facing the move.
    function automatic int wall_move(input int h, input int v, input int dir);
        int x0, y0, x1, y1;
        x0 = h; y0 = v; x1 = h + TS - 1; y1 = v;
        case (dir)
            1: begin x0 = h; x1 = h + TS - 1; y0 = v + TS - 1; y1 = v + TS - 1; end
            2: begin x0 = h; x1 = h; y0 = v; y1 = v + TS - 1; end
            3: begin x0 = h + TS - 1; x1 = h + TS - 1; y0 = v; y1 = v + TS - 1; end
            default: ;
        endcase
        return (wall_pt(x0, y0) != 0 || wall_pt(x1, y1) != 0) ? 1 : 0;
    endfunction

    function automatic int enemy_touch(input int h, input int v);
        for (int k = 0; k < N_ENEMY; k++)
            if (iabs(h - en_h[k]) < TS && iabs(v - en_v[k]) < TS) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_h = START_H; m_v = START_V; m_face = 1; m_hit = 0; m_cool = 0; m_cnt = 0;
        m_pend = 0; m_ch = 0; m_cv = 0; m_cdir = 1; m_coob = 0;
    endtask

    task automatic model_step();
        int tick, expire, wall, en, dir, nh, nv, n_cool;
        if (rst) begin
            model_reset();
            return;
        end
        tick   = (m_cnt == ((MOVE_DIV > 1) ? MOVE_DIV - 1 : 0)) ? 1 : 0;
        m_cnt  = tick ? 0 : m_cnt + 1;
        expire = (tick != 0 && m_cool == 1) ? 1 : 0;
        n_cool = m_cool;
        m_hit  = 0;
        if (m_pend != 0) begin
            wall = (m_coob != 0 || wall_move(m_ch, m_cv, m_cdir) != 0) ? 1 : 0;
            en   = enemy_touch(m_ch, m_cv);
            m_face = m_cdir;
            if (wall == 0 && en == 0) begin
                m_h = m_ch;
                m_v = m_cv;
            end
            if (en != 0 && m_cool == 0) begin
                m_hit  = 1;
                n_cool = HIT_COOLDOWN;
            end
        end
        if (m_cool > 0 && tick != 0) n_cool = m_cool - 1;
        if (m_pend == 0 && tick != 0 && $countones(move_req) == 1 && expire == 0) begin
            dir = (move_req == 4'b1000) ? 0 : (move_req == 4'b0100) ? 1 :
                  (move_req == 4'b0010) ? 2 : 3;
            nh = m_h + ((dir == 2) ? -STEP : (dir == 3) ? STEP : 0);
            nv = m_v + ((dir == 0) ? -STEP : (dir == 1) ? STEP : 0);
            m_coob = (nh < 0 || nh > 1023 || nv < 0 || nv > 1023) ? 1 : 0;
            m_ch   = nh & 1023;
            m_cv   = nv & 1023;
            m_cdir = dir;
            m_pend = 1;
        end else if (m_pend != 0) begin
            m_pend = 0;
        end
        m_cool = n_cool;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_enemies();
        for (int k = 0; k < N_ENEMY; k++)
            enemy_pos[20*k +: 20] = {10'(en_h[k]), 10'(en_v[k])};
    endtask

    task automatic enemies_far();
        for (int k = 0; k < N_ENEMY; k++) begin
            en_h[k] = 1000;
            en_v[k] = 1000;
        end
        drive_enemies();
    endtask

    task automatic compare_all();
        check_val("pos_h",     int'(position[19:10]), m_h);
        check_val("pos_v",     int'(position[9:0]),   m_v);
        check_val("facing",    int'(facing),          m_face);
        check_val("enemy_hit", int'(enemy_hit),       m_hit);
        check_val("invuln",    int'(invuln),          (m_cool > 0) ? 1 : 0);
        check_val("busy",      int'(busy),            m_pend);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        move_req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic hold(input logic [3:0] req, input int n);
        move_req = req;
        for (int i = 0; i < n; i++) step();
    endtask

    int pulses;
    int rnd;

    initial begin
        rst = 1'b1;
        move_req = 4'b0000;
        wall_map = '0;
        enemies_far();
        model_reset();

        // Reset state
        do_reset();
        check_val("rst_pos", int'(position), (START_H << 10) | START_V);
        check_val("rst_facing", int'(facing), 1);
        check_val("rst_flags", int'({enemy_hit, invuln, busy}), 0);
        $display("[TB] reset: position=%0d,%0d facing=%0d", position[19:10], position[9:0], facing);

        // Free move down: v advances every two clocks
        move_req = 4'b0100;
        step(); step();
        check_val("free_v1", int'(position[9:0]), 34);
        step(); step();
        check_val("free_v2", int'(position[9:0]), 36);
        step(); step();
        check_val("free_v3", int'(position[9:0]), 38);
        check_val("free_facing", int'(facing), 1);
        move_req = 4'b0000;
        step();
        $display("[TB] free move: v=%0d facing=%0d", position[9:0], facing);

        // Illegal requests never start an evaluation
        for (int i = 0; i < 20; i++) begin
            move_req = (i < 10) ? 4'b1010 : 4'b0000;
            step();
            check_val("illegal_busy", int'(busy), 0);
            check_val("illegal_v", int'(position[9:0]), 38);
        end
        $display("[TB] illegal request: position=%0d,%0d", position[19:10], position[9:0]);

        // Wall in column 2: from h=174 one step right fits, the next is blocked
        do_reset();
        hold(4'b0010, 6);
        check_val("wall_pre_h", int'(position[19:10]), 174);
        for (int r = 0; r < MAP_H; r++) wall_map[r*MAP_W + 2] = 1'b1;
        hold(4'b0001, 8);
        check_val("wall_h", int'(position[19:10]), 176);
        check_val("wall_facing", int'(facing), 3);
        check_val("wall_nohit", int'(enemy_hit), 0);
        move_req = 4'b0000;
        wall_map = '0;
        do_reset();
        $display("[TB] wall block: stopped at h=176");

        // Boundary: stepping above the map origin is a wall, not a wrap
        hold(4'b1000, 6);
        check_val("bound_v", int'(position[9:0]), 32);
        check_val("bound_facing", int'(facing), 0);
        move_req = 4'b0000;
        $display("[TB] boundary up: v=%0d", position[9:0]);

        // Enemy hit, cooldown, and re-hit after expiry while still touching
        do_reset();
        en_h[0] = 212; en_v[0] = 32;
        drive_enemies();
        move_req = 4'b0001;
        pulses = 0;
        for (int s = 1; s <= 64; s++) begin
            step();
            check_val("hit_pulse", int'(enemy_hit), (s == 2 || s == 64) ? 1 : 0);
            if (s == 61) check_val("invuln_last", int'(invuln), 1);
            if (s == 62) check_val("invuln_clear", int'(invuln), 0);
            if (enemy_hit) pulses++;
        end
        check_val("hit_count", pulses, 2);
        check_val("hit_h", int'(position[19:10]), 180);
        $display("[TB] enemy hit: %0d pulses in 64 clocks", pulses);

        // Reset during cooldown after moving away
        do_reset();
        hold(4'b0001, 3);
        check_val("mid_invuln", int'(invuln), 1);
        hold(4'b0010, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("midrst_pos", int'(position), (START_H << 10) | START_V);
        check_val("midrst_invuln", int'(invuln), 0);
        check_val("midrst_facing", int'(facing), 1);
        check_val("midrst_hit", int'(enemy_hit), 0);
        $display("[TB] reset mid-hit: position=%0d,%0d", position[19:10], position[9:0]);

        // Random play
        enemies_far();
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                for (int b = 0; b < MAP_W*MAP_H; b++) wall_map[b] = ($urandom_range(0, 99) < 8);
                for (int r = 0; r < 2; r++)
                    for (int col = 1; col < 3; col++) wall_map[r*MAP_W + col] = 1'b0;
                rst = 1'b1;
            end
            if (c % 40 == 5) begin
                for (int k = 0; k < N_ENEMY; k++) begin
                    en_h[k] = $urandom_range(100, 600);
                    en_v[k] = $urandom_range(0, 500);
                end
                en_h[0] = (m_h + $urandom_range(0, 80) > 40) ? m_h + $urandom_range(0, 80) - 40 : 0;
                en_v[0] = (m_v + $urandom_range(0, 80) > 40) ? m_v + $urandom_range(0, 80) - 40 : 0;
                if (en_h[0] > 1023) en_h[0] = 1023;
                if (en_v[0] > 1023) en_v[0] = 1023;
                drive_enemies();
            end
            rnd = $urandom_range(0, 9);
            if (rnd < 6)      move_req = 4'b0001 << $urandom_range(0, 3);
            else if (rnd < 8) move_req = 4'b0000;
            else              move_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        $display("[TB] random play: final position=%0d,%0d", position[19:10], position[9:0]);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
